tape_adc_slicer: RTL and testbench
==================================

Name: tape_adc_slicer

Overview:
- Cassette-input front end. Drives an LTC2308 12-bit SPI ADC on the 4-wire ADC_BUS, sampling channel 0 single-ended unipolar at a fixed rate.
- Slices each sample to a 1-bit tape level with hysteresis, and flags whether a tape signal is present.
- Sits between the board ADC header and the system glue; the top level uses dout & active as the tape input.

Parameters:
- CLK_RATE, 50000000, clk frequency in Hz.
- ADC_RATE, 48000, conversion start rate in Hz; sample period SP = CLK_RATE/ADC_RATE clk cycles (integer division).
- CONV_CYCLES, 85, clk cycles CONVST is held high (≥1.6 µs at CLK_RATE).
- HIST_LOW, 16, 12-bit threshold; a sample strictly below it forces the level to 0.
- HIST_HIGH, 64, 12-bit threshold; a sample strictly above it forces the level to 1.
- ACT_SAMPLES, 24000, samples without a level edge before active drops (0.5 s).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- ADC_BUS, inout, 4: [0]=CONVST out, [1]=SDI out (config to ADC), [2]=SDO in (driven Z by this block), [3]=SCK out.
- dout, out, 1: hysteresis-sliced tape level.
- active, out, 1: high while tape edges were seen within the last ACT_SAMPLES samples.

Behaviour:
- Reset (async): CONVST=0, SCK=0, SDI=0, dout=0, active=0, sample counter=0, FSM=IDLE, activity counter=0.
- A period counter counts 0..SP-1 and wraps.
- FSM IDLE: at period count 0 → CONV with CONVST=1.
- CONV: hold for CONV_CYCLES clks → CONVST=0 → SHIFT.
- SHIFT: 12 SCK pulses, 2 clk low then 2 clk high each (SCK = clk/4).
  - SDI presents config word 6'b100010 MSB first (S/D=1, O/S=0, S1=0, S0=0, UNI=1, SLP=0). Each bit changes while SCK is low; bits 7..12 send 0.
  - SDO is sampled on each SCK rising edge into a 12-bit shift register, MSB first.
  - After the 12th high phase, SCK returns to 0 → DONE.
- DONE (1 clk): latch the 12-bit sample, update the level, then → IDLE.
- Level update: sample < HIST_LOW → dout=0; sample > HIST_HIGH → dout=1; otherwise hold. Boundary values equal to either threshold hold the level. dout changes exactly 1 clk after DONE.
- Activity: on a sample where dout changes value, reload the counter to ACT_SAMPLES. Otherwise decrement once per sample, saturating at 0.
- active = (counter != 0), registered. The first edge sets active in the same update.
- Timing budget: SP must exceed CONV_CYCLES + 48 + 2. If the period wraps mid-transaction, the transaction completes and the next start waits for the following count 0. No overlap.
- Reset mid-transaction aborts immediately; ADC lines go idle (CONVST=0, SCK=0).

Decomposition:
- Shared package tape_adc_pkg holds:
  - FSM state enum (IDLE, CONV, SHIFT, DONE);
  - localparam CFG_CH0_UNI = 6'b100010;
  - the sample width (12).
- One natural sub-module, ltc2308_spi_ctrl: period counter, CONVST/SCK/SDI generation, SDO capture. It outputs a 12-bit sample plus a 1-clk sample_valid strobe.
- The top level does the hysteresis slicing and activity timing.

Test Plan:
- Reset then release; observe for 2 sample periods → CONVST pulses every 1041 clks, each 85 clks wide; exactly 12 SCK rising edges per period; SDI bit sequence 1,0,0,0,1,0 followed by six 0s.
- ADC model returns 12'h800 → dout=1 one clk after DONE; then returns 12'h000 → dout=0.
- Boundaries from dout=0: 40 holds 0; 64 holds 0; 65 sets 1. Then from dout=1: 16 holds 1; 15 clears 0.
- Alternate samples 0 / 2000 → active=1 after the first edge. Then constant 2000 → active stays 1 for 24000 samples and drops to 0 on the 24000th non-edge sample.
- Assert reset during SHIFT → CONVST=0, SCK=0, dout=0, active=0 within the same clk. After release, the next CONVST occurs at period count 0.
- ADC model with a constant value (no edges) → active stays 0 indefinitely.

Source files
------------

// File: rtl/tape_adc_slicer_pkg.sv
// Shared types and constants for the cassette ADC front end.
// Holds the LTC2308 controller state encoding and the channel-0 config word.
package tape_adc_pkg;

    localparam int SAMPLE_W = 12;

    // S/D=1, O/S=0, S1=0, S0=0, UNI=1, SLP=0: channel 0, single-ended, unipolar
    localparam logic [5:0] CFG_CH0_UNI = 6'b100010;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        DONE
    } adc_state_t;

    // Config bit presented during SCK bit slot idx (0..11); slots 6..11 send 0
    function automatic logic cfg_bit(input logic [3:0] idx);
        logic [11:0] word;
        word = {CFG_CH0_UNI, 6'b000000};
        return word[4'd11 - idx];
    endfunction

endpackage

// File: rtl/tape_adc_slicer_if.sv
// LTC2308 4-wire serial bus as seen by the conversion controller (master)
// and by the ADC itself (slave).
interface tape_adc_slicer_if;
    logic convst;
    logic sdi;
    logic sdo;
    logic sck;

    modport master (output convst, output sdi, output sck, input sdo);
    modport slave  (input convst, input sdi, input sck, output sdo);
endinterface

// File: rtl/tape_adc_slicer_spi_ctrl.sv
// LTC2308 conversion sequencer: fixed-rate CONVST, 12 SCK pulses at clk/4,
// config word out on SDI, sample captured from SDO with a 1-clk valid strobe.
module ltc2308_spi_ctrl
    import tape_adc_pkg::*;
#(
    parameter int CLK_RATE    = 50000000,
    parameter int ADC_RATE    = 48000,
    parameter int CONV_CYCLES = 85
) (
    input  logic                clk,
    input  logic                reset,
    tape_adc_slicer_if.master   adc,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid
);

    localparam int SP = CLK_RATE / ADC_RATE;
    localparam int PW = $clog2(SP);
    localparam int CW = $clog2(CONV_CYCLES + 1);

    logic [PW-1:0]       period_cnt;
    logic [CW-1:0]       conv_cnt;
    logic [5:0]          shift_cnt;
    logic [5:0]          shift_next;
    logic [SAMPLE_W-1:0] shift_reg;
    adc_state_t          state;

    assign shift_next = shift_cnt + 6'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (period_cnt == PW'(SP - 1)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // shift_cnt[1] is the SCK level of each 4-clk bit slot, shift_cnt[5:2] the bit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            adc.convst   <= 1'b0;
            adc.sck      <= 1'b0;
            adc.sdi      <= 1'b0;
            conv_cnt     <= '0;
            shift_cnt    <= '0;
            shift_reg    <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (period_cnt == '0) begin
                        state      <= CONV;
                        adc.convst <= 1'b1;
                        conv_cnt   <= '0;
                    end
                end
                CONV: begin
                    if (conv_cnt == CW'(CONV_CYCLES - 1)) begin
                        state      <= SHIFT;
                        adc.convst <= 1'b0;
                        adc.sck    <= 1'b0;
                        adc.sdi    <= cfg_bit(4'd0);
                        shift_cnt  <= '0;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (shift_cnt[1:0] == 2'd1) begin
                        shift_reg <= {shift_reg[SAMPLE_W-2:0], adc.sdo};
                    end
                    if (shift_cnt == 6'd47) begin
                        state        <= DONE;
                        adc.sck      <= 1'b0;
                        sample       <= shift_reg;
                        sample_valid <= 1'b1;
                    end else begin
                        shift_cnt <= shift_next;
                        adc.sck   <= shift_next[1];
                        adc.sdi   <= cfg_bit(shift_next[5:2]);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    adc.sdi <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tape_adc_slicer.sv
// Cassette input front end: samples the tape signal through an LTC2308 and
// slices it to a 1-bit level with hysteresis plus a signal-present flag.
module tape_adc_slicer
    import tape_adc_pkg::*;
#(
    parameter int                  CLK_RATE    = 50000000,
    parameter int                  ADC_RATE    = 48000,
    parameter int                  CONV_CYCLES = 85,
    parameter logic [SAMPLE_W-1:0] HIST_LOW    = 12'd16,
    parameter logic [SAMPLE_W-1:0] HIST_HIGH   = 12'd64,
    parameter int                  ACT_SAMPLES = 24000
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire  [3:0] ADC_BUS,
    output logic       dout,
    output logic       active
);

    localparam int AW = $clog2(ACT_SAMPLES + 1);

    tape_adc_slicer_if adc_bus ();

    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic                level_next;
    logic [AW-1:0]       act_cnt;
    logic [AW-1:0]       act_next;

    // SDO is an ADC output, so this block never drives bit 2
    assign ADC_BUS[0]  = adc_bus.convst;
    assign ADC_BUS[1]  = adc_bus.sdi;
    assign ADC_BUS[2]  = 1'bz;
    assign ADC_BUS[3]  = adc_bus.sck;
    assign adc_bus.sdo = ADC_BUS[2];

    ltc2308_spi_ctrl #(
        .CLK_RATE    (CLK_RATE),
        .ADC_RATE    (ADC_RATE),
        .CONV_CYCLES (CONV_CYCLES)
    ) u_spi_ctrl (
        .clk          (clk),
        .reset        (reset),
        .adc          (adc_bus.master),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    always_comb begin
        level_next = dout;
        if (sample < HIST_LOW) begin
            level_next = 1'b0;
        end else if (sample > HIST_HIGH) begin
            level_next = 1'b1;
        end

        act_next = act_cnt;
        if (level_next != dout) begin
            act_next = AW'(ACT_SAMPLES);
        end else if (act_cnt != '0) begin
            act_next = act_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout    <= 1'b0;
            act_cnt <= '0;
            active  <= 1'b0;
        end else if (sample_valid) begin
            dout    <= level_next;
            act_cnt <= act_next;
            active  <= (act_next != '0);
        end
    end

endmodule

// File: tb/tb_tape_adc_slicer.sv
// Directed bench for tape_adc_slicer: a small LTC2308 model answers on SDO
// while bus timing, slicer levels and the activity flag are checked.
module tb_tape_adc_slicer;

    localparam int ACT_N = 6;

    logic       clk = 1'b0;
    logic       reset;
    wire  [3:0] adc_pins;
    logic       dout;
    logic       active;

    tape_adc_slicer_if adc ();

    assign adc.convst  = adc_pins[0];
    assign adc.sdi     = adc_pins[1];
    assign adc.sck     = adc_pins[3];
    assign adc_pins[2] = adc.sdo;

    tape_adc_slicer #(
        .ACT_SAMPLES (ACT_N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ADC_BUS (adc_pins),
        .dout    (dout),
        .active  (active)
    );

    always #10 clk = ~clk;

    int          checks = 0;
    int          fails = 0;
    int          cycle = 0;
    logic [11:0] adc_value = 12'h000;
    logic [11:0] shift_out = 12'h000;
    logic [11:0] sdi_bits = 12'h000;
    logic        prev_convst = 1'b0;
    logic        prev_sck = 1'b0;
    logic        rise_valid = 1'b0;
    int          rise_cycle = 0;
    int          last_period = 0;
    int          last_width = 0;
    int          sck_rises = 0;
    int          done_count = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // ADC model: MSB appears when CONVST falls, next bit after each SCK fall
    always @(posedge clk) begin
        #1;
        if (reset) begin
            prev_convst = 1'b0;
            prev_sck    = 1'b0;
            sck_rises   = 0;
            sdi_bits    = 12'h000;
            rise_valid  = 1'b0;
            adc.sdo     = 1'b0;
        end else begin
            if (adc.convst && !prev_convst) begin
                if (rise_valid) last_period = cycle - rise_cycle;
                rise_cycle = cycle;
                rise_valid = 1'b1;
                sck_rises  = 0;
                sdi_bits   = 12'h000;
            end
            if (!adc.convst && prev_convst) begin
                last_width = cycle - rise_cycle;
                shift_out  = adc_value;
                adc.sdo    = shift_out[11];
            end
            if (adc.sck && !prev_sck) begin
                sck_rises = sck_rises + 1;
                sdi_bits  = {sdi_bits[10:0], adc.sdi};
            end
            if (!adc.sck && prev_sck) begin
                shift_out = {shift_out[10:0], 1'b0};
                adc.sdo   = shift_out[11];
                if (sck_rises == 12) done_count = done_count + 1;
            end
            prev_convst = adc.convst;
            prev_sck    = adc.sck;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitDone();
        int start;
        start = done_count;
        for (int i = 0; i < 3000 && done_count == start; i++) @(negedge clk);
        if (done_count == start) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    // Returns on the negedge inside DONE; dout must still hold its old level there
    task automatic applyStimulus(input string tag, input logic [11:0] value,
                                 input logic exp_before, input logic exp_dout,
                                 input logic exp_active);
        adc_value = value;
        waitDone();
        checkOutput({tag, "_dout_before"}, 32'(dout), 32'(exp_before));
        @(negedge clk);
        checkOutput({tag, "_dout"}, 32'(dout), 32'(exp_dout));
        checkOutput({tag, "_active"}, 32'(active), 32'(exp_active));
    endtask

    logic [11:0] vec_value  [0:16];
    logic        vec_dout   [0:16];
    logic        vec_active [0:16];

    initial begin
        int waited;
        logic level;

        // value, sliced level, activity flag (ACT_N = 6 samples)
        vec_value = '{12'h800, 12'h000, 12'd40, 12'd64, 12'd65, 12'd16, 12'd15,
                      12'd2000, 12'd0, 12'd2000,
                      12'd2000, 12'd2000, 12'd2000, 12'd2000, 12'd2000, 12'd2000,
                      12'd2000};
        vec_dout   = '{1, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        vec_active = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_convst", 32'(adc.convst), 32'd0);
        checkOutput("reset_sck", 32'(adc.sck), 32'd0);
        checkOutput("reset_sdi", 32'(adc.sdi), 32'd0);
        checkOutput("reset_dout", 32'(dout), 32'd0);
        checkOutput("reset_active", 32'(active), 32'd0);
        reset = 1'b0;

        waitDone();
        waitDone();
        checkOutput("convst_period", 32'(last_period), 32'd1041);
        checkOutput("convst_width", 32'(last_width), 32'd85);
        checkOutput("sck_rises", 32'(sck_rises), 32'd12);
        checkOutput("sdi_sequence", 32'(sdi_bits), 32'h880);
        checkOutput("zero_dout", 32'(dout), 32'd0);
        checkOutput("zero_active", 32'(active), 32'd0);

        level = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            applyStimulus($sformatf("vec%0d", i), vec_value[i], level, vec_dout[i],
                          vec_active[i]);
            level = vec_dout[i];
        end

        adc_value = 12'h000;
        waited = 0;
        while (!(sck_rises >= 3 && adc.sck) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("shift_reached", 32'(waited < 3000), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort_convst", 32'(adc.convst), 32'd0);
        checkOutput("abort_sck", 32'(adc.sck), 32'd0);
        checkOutput("abort_dout", 32'(dout), 32'd0);
        checkOutput("abort_active", 32'(active), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        waited = 0;
        while (!adc.convst && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("restart_delay", 32'(waited), 32'd1);

        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("quiet%0d", i), 12'h000, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
